// File: rtl/pe_r4_pipe.sv
// Pipelined radix-4 DIT butterfly: S1 twiddle multiply, S2 butterfly sums, S3 scale/saturate.
// Optional saturating overflow-vector counter is built when PE_OVF_CNT_EN is defined.
module pe_r4_pipe #(
  parameter int WL  = 16,
  parameter int IWL = 5,
  parameter int FWL = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_scale,
  input  logic [4*WL-1:0] x_r,
  input  logic [4*WL-1:0] x_i,
  input  logic [3*WL-1:0] w_r,
  input  logic [3*WL-1:0] w_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*WL-1:0] y_r,
  output logic [4*WL-1:0] y_i,
  output logic            out_ovf
`ifdef PE_OVF_CNT_EN
  ,
  output logic [15:0]     ovf_cnt,
  input  logic            ovf_clr
`endif
);

  localparam int PW = 2*WL + 1;
  localparam int SW = WL + 2;
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-IWL-FWL){1'b0}}, {(IWL+FWL){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-IWL-FWL){1'b1}}, {(IWL+FWL){1'b0}}};
  localparam logic signed [PW-1:0] RND     = {{(PW-FWL){1'b0}}, 1'b1, {(FWL-1){1'b0}}};

  // Returns {overflow flag, saturated WL-bit value}.
  function automatic logic [WL:0] sat_f(input logic signed [PW-1:0] v);
    logic [WL:0] r;
    if (v > SAT_MAX)      r = {1'b1, SAT_MAX[WL-1:0]};
    else if (v < SAT_MIN) r = {1'b1, SAT_MIN[WL-1:0]};
    else                  r = {1'b0, v[WL-1:0]};
    return r;
  endfunction

  function automatic logic [2*WL-1:0] sx2(input logic [WL-1:0] v);
    return {{WL{v[WL-1]}}, v};
  endfunction

  function automatic logic signed [SW-1:0] e2(input logic [WL-1:0] v);
    return {{2{v[WL-1]}}, v};
  endfunction

  // Optional divide-by-4 with round half-up, widened to the saturation width.
  function automatic logic signed [PW-1:0] scl_f(input logic signed [SW-1:0] s, input logic sc);
    logic signed [SW:0] t;
    logic signed [SW:0] q;
    t = {s[SW-1], s} + {{(SW-1){1'b0}}, 2'b10};
    q = t >>> 2;
    return sc ? {{(PW-SW-1){q[SW]}}, q} : {{(PW-SW){s[SW-1]}}, s};
  endfunction

  logic w_en1, w_en2, w_en3;
  logic r_v1, r_v2, r_v3;

  assign w_en3    = ~r_v3 | out_ready;
  assign w_en2    = ~r_v2 | w_en3;
  assign w_en1    = ~r_v1 | w_en2;
  assign in_ready = w_en1;

  logic [WL-1:0] w_xr [4];
  logic [WL-1:0] w_xi [4];
  logic [WL-1:0] w_wr [1:3];
  logic [WL-1:0] w_wi [1:3];
  logic [WL:0]   w_p_r [1:3];
  logic [WL:0]   w_p_i [1:3];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack_x
      assign w_xr[gi] = x_r[gi*WL +: WL];
      assign w_xi[gi] = x_i[gi*WL +: WL];
    end
    for (gi = 1; gi < 4; gi++) begin : g_mul
      logic [2*WL-1:0]       w_rr, w_ii, w_ri, w_ir;
      logic signed [PW-1:0]  w_re_sum, w_im_sum, w_re_sh, w_im_sh;
      assign w_wr[gi] = w_r[(gi-1)*WL +: WL];
      assign w_wi[gi] = w_i[(gi-1)*WL +: WL];
      // Sign-extended operands make the low 2WL product bits exact two's complement.
      assign w_rr = sx2(w_xr[gi]) * sx2(w_wr[gi]);
      assign w_ii = sx2(w_xi[gi]) * sx2(w_wi[gi]);
      assign w_ri = sx2(w_xr[gi]) * sx2(w_wi[gi]);
      assign w_ir = sx2(w_xi[gi]) * sx2(w_wr[gi]);
      assign w_re_sum = {w_rr[2*WL-1], w_rr} - {w_ii[2*WL-1], w_ii} + RND;
      assign w_im_sum = {w_ri[2*WL-1], w_ri} + {w_ir[2*WL-1], w_ir} + RND;
      assign w_re_sh  = w_re_sum >>> FWL;
      assign w_im_sh  = w_im_sum >>> FWL;
      assign w_p_r[gi] = sat_f(w_re_sh);
      assign w_p_i[gi] = sat_f(w_im_sh);
    end
  endgenerate

  logic w_ovf1;
  assign w_ovf1 = w_p_r[1][WL] | w_p_i[1][WL] | w_p_r[2][WL] | w_p_i[2][WL]
                | w_p_r[3][WL] | w_p_i[3][WL];

  // S1: index 0 holds a = x0, indices 1..3 hold b, c, d.
  logic [WL-1:0] r_t_r [4];
  logic [WL-1:0] r_t_i [4];
  logic          r_scale1, r_ovf1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1     <= 1'b0;
      r_scale1 <= 1'b0;
      r_ovf1   <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_t_r[k] <= '0;
        r_t_i[k] <= '0;
      end
    end else if (w_en1) begin
      r_v1     <= in_valid;
      r_scale1 <= in_scale;
      r_ovf1   <= w_ovf1;
      r_t_r[0] <= w_xr[0];
      r_t_i[0] <= w_xi[0];
      for (int k = 1; k < 4; k++) begin
        r_t_r[k] <= w_p_r[k][WL-1:0];
        r_t_i[k] <= w_p_i[k][WL-1:0];
      end
    end
  end

  logic signed [SW-1:0] w_e_r [4];
  logic signed [SW-1:0] w_e_i [4];
  logic signed [SW-1:0] w_s_r [4];
  logic signed [SW-1:0] w_s_i [4];

  generate
    for (gi = 0; gi < 4; gi++) begin : g_ext
      assign w_e_r[gi] = e2(r_t_r[gi]);
      assign w_e_i[gi] = e2(r_t_i[gi]);
    end
  endgenerate

  // -j*(r,i) = (i,-r) and +j*(r,i) = (-i,r) fold into the X1/X3 lane sums.
  assign w_s_r[0] = w_e_r[0] + w_e_r[1] + w_e_r[2] + w_e_r[3];
  assign w_s_i[0] = w_e_i[0] + w_e_i[1] + w_e_i[2] + w_e_i[3];
  assign w_s_r[1] = w_e_r[0] + w_e_i[1] - w_e_r[2] - w_e_i[3];
  assign w_s_i[1] = w_e_i[0] - w_e_r[1] - w_e_i[2] + w_e_r[3];
  assign w_s_r[2] = w_e_r[0] - w_e_r[1] + w_e_r[2] - w_e_r[3];
  assign w_s_i[2] = w_e_i[0] - w_e_i[1] + w_e_i[2] - w_e_i[3];
  assign w_s_r[3] = w_e_r[0] - w_e_i[1] - w_e_r[2] + w_e_i[3];
  assign w_s_i[3] = w_e_i[0] + w_e_r[1] - w_e_i[2] - w_e_r[3];

  logic signed [SW-1:0] r_s_r [4];
  logic signed [SW-1:0] r_s_i [4];
  logic                 r_scale2, r_ovf2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2     <= 1'b0;
      r_scale2 <= 1'b0;
      r_ovf2   <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_s_r[k] <= '0;
        r_s_i[k] <= '0;
      end
    end else if (w_en2) begin
      r_v2     <= r_v1;
      r_scale2 <= r_scale1;
      r_ovf2   <= r_ovf1;
      for (int k = 0; k < 4; k++) begin
        r_s_r[k] <= w_s_r[k];
        r_s_i[k] <= w_s_i[k];
      end
    end
  end

  logic [WL:0]   w_q_r [4];
  logic [WL:0]   w_q_i [4];
  logic [3:0]    w_f3;
  logic [WL-1:0] r_y_r [4];
  logic [WL-1:0] r_y_i [4];
  logic          r_ovf3;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_out
      assign w_q_r[gi] = sat_f(scl_f(r_s_r[gi], r_scale2));
      assign w_q_i[gi] = sat_f(scl_f(r_s_i[gi], r_scale2));
      assign w_f3[gi]  = w_q_r[gi][WL] | w_q_i[gi][WL];
      assign y_r[gi*WL +: WL] = r_y_r[gi];
      assign y_i[gi*WL +: WL] = r_y_i[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3   <= 1'b0;
      r_ovf3 <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_y_r[k] <= '0;
        r_y_i[k] <= '0;
      end
    end else if (w_en3) begin
      r_v3   <= r_v2;
      r_ovf3 <= r_ovf2 | (|w_f3);
      for (int k = 0; k < 4; k++) begin
        r_y_r[k] <= w_q_r[k][WL-1:0];
        r_y_i[k] <= w_q_i[k][WL-1:0];
      end
    end
  end

  assign out_valid = r_v3;
  assign out_ovf   = r_ovf3;

`ifdef PE_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  // Clear dominates a same-cycle increment; count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ovf_cnt <= '0;
    else if (ovf_clr)
      r_ovf_cnt <= '0;
    else if (r_v3 && out_ready && r_ovf3 && (r_ovf_cnt != 16'hFFFF))
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_pe_r4_pipe.sv
// Scoreboard bench for pe_r4_pipe: directed spec vectors, backpressure, random stalls, mid-stream reset.
// Counter checks are compiled in when PE_OVF_CNT_EN is defined.
module tb_pe_r4_pipe;
  localparam int WL = 16;
  localparam int FWL = 10;
  localparam longint MAXV = 32767;
  localparam longint MINV = -32768;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_scale = 1'b0;
  logic [63:0] x_r = '0, x_i = '0;
  logic [47:0] w_r = '0, w_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] y_r, y_i;
  logic        out_ovf;
`ifdef PE_OVF_CNT_EN
  logic [15:0] ovf_cnt;
  logic        ovf_clr = 1'b0;
`endif

  pe_r4_pipe #(.WL(16), .IWL(5), .FWL(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_scale(in_scale),
    .x_r(x_r), .x_i(x_i), .w_r(w_r), .w_i(w_i),
    .out_valid(out_valid), .out_ready(out_ready), .y_r(y_r), .y_i(y_i), .out_ovf(out_ovf)
`ifdef PE_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_out = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] yr;
    logic [63:0] yi;
    logic        ov;
    int          acc;
    bit          lat;
  } exp_t;
  exp_t q[$];

  logic [63:0] cur_yr, cur_yi;
  logic        cur_ov;
  bit          cur_lat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint sx(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint clip(input longint v);
    return (v > MAXV) ? MAXV : ((v < MINV) ? MINV : v);
  endfunction

  // Reference: X_k = sum_n a_n * (-j)^(n*k), with products rounded half-up and clipped.
  task automatic model(input logic [63:0] xr, input logic [63:0] xi, input logic [47:0] wr,
                       input logic [47:0] wi, input bit sc,
                       output logic [63:0] yr, output logic [63:0] yi, output logic ov);
    longint ar[4], ai[4];
    longint pr, pi, a, b, c, d, sr, si, tr, ti, tmp;
    ov = 1'b0;
    yr = '0;
    yi = '0;
    ar[0] = sx(xr[15:0]);
    ai[0] = sx(xi[15:0]);
    for (int n = 1; n < 4; n++) begin
      a = sx(xr[n*16 +: 16]);
      b = sx(xi[n*16 +: 16]);
      c = sx(wr[(n-1)*16 +: 16]);
      d = sx(wi[(n-1)*16 +: 16]);
      pr = (a*c - b*d + (64'sd1 <<< (FWL-1))) >>> FWL;
      pi = (a*d + b*c + (64'sd1 <<< (FWL-1))) >>> FWL;
      if (pr != clip(pr) || pi != clip(pi)) ov = 1'b1;
      ar[n] = clip(pr);
      ai[n] = clip(pi);
    end
    for (int k = 0; k < 4; k++) begin
      sr = 0;
      si = 0;
      for (int n = 0; n < 4; n++) begin
        tr = ar[n];
        ti = ai[n];
        for (int m = 0; m < (n*k) % 4; m++) begin
          tmp = tr;
          tr  = ti;
          ti  = -tmp;
        end
        sr += tr;
        si += ti;
      end
      if (sc) begin
        sr = (sr + 2) >>> 2;
        si = (si + 2) >>> 2;
      end
      if (sr != clip(sr) || si != clip(si)) ov = 1'b1;
      tmp = clip(sr);
      yr[k*16 +: 16] = tmp[15:0];
      tmp = clip(si);
      yi[k*16 +: 16] = tmp[15:0];
    end
  endtask

  // Presents one vector and returns just after the edge that accepted it.
  task automatic send(input logic [63:0] xr, input logic [63:0] xi, input logic [47:0] wr,
                      input logic [47:0] wi, input bit sc, input bit lat, input bit dir,
                      input logic [63:0] eyr, input logic [63:0] eyi, input logic eov);
    bit hs = 0;
    int n = 0;
    if (dir) begin
      cur_yr = eyr;
      cur_yi = eyi;
      cur_ov = eov;
    end else begin
      model(xr, xi, wr, wi, sc, cur_yr, cur_yi, cur_ov);
    end
    cur_lat  = lat;
    x_r      = xr;
    x_i      = xi;
    w_r      = wr;
    w_i      = wi;
    in_scale = sc;
    in_valid = 1'b1;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) chk("in_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [15:0] rnd_word();
    int s;
    s = $urandom_range(0, 7);
    if (s == 0) return 16'h8000;
    if (s == 1) return 16'h7FFF;
    if (s == 2) return 16'h0400;
    return 16'($urandom);
  endfunction

  task automatic rnd_vec(output logic [63:0] xr, output logic [63:0] xi,
                         output logic [47:0] wr, output logic [47:0] wi);
    xr = {rnd_word(), rnd_word(), rnd_word(), rnd_word()};
    xi = {rnd_word(), rnd_word(), rnd_word(), rnd_word()};
    wr = {rnd_word(), rnd_word(), rnd_word()};
    wi = {rnd_word(), rnd_word(), rnd_word()};
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop/compare on output handshakes, push expectations on input handshakes.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk("y_r", y_r, e.yr);
        chk("y_i", y_i, e.yi);
        chk("out_ovf", 64'(out_ovf), 64'(e.ov));
        if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd3);
        $display("txn %0d: y_r=%h y_i=%h ovf=%0b", n_out, y_r, y_i, out_ovf);
        n_out++;
      end
    end
    if (rst_n && in_valid && in_ready) begin
      q.push_back('{cur_yr, cur_yi, cur_ov, cyc, cur_lat});
      n_acc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  localparam logic [47:0] W_ONE = {3{16'h0400}};

  initial begin
    logic [63:0] xr, xi;
    logic [47:0] wr, wi;
    int acc0;
    bit done;

    // Reset state
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_y_r", y_r, 64'd0);
    chk("rst_y_i", y_i, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef PE_OVF_CNT_EN
    chk("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
`endif
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Impulse
    send({48'd0, 16'h0400}, 64'd0, W_ONE, 48'd0, 1'b0, 1'b1, 1'b1,
         {4{16'h0400}}, 64'd0, 1'b0);
    // DC, unscaled and scaled
    send({4{16'h0400}}, 64'd0, W_ONE, 48'd0, 1'b0, 1'b1, 1'b1,
         {48'd0, 16'h1000}, 64'd0, 1'b0);
    send({4{16'h0400}}, 64'd0, W_ONE, 48'd0, 1'b1, 1'b1, 1'b1,
         {48'd0, 16'h0400}, 64'd0, 1'b0);
    // Twiddle -j on x1
    send({32'd0, 16'h0400, 16'h0000}, 64'd0, 48'd0, {32'd0, 16'hFC00}, 1'b0, 1'b1, 1'b1,
         {16'h0400, 16'h0000, 16'hFC00, 16'h0000},
         {16'h0000, 16'h0400, 16'h0000, 16'hFC00}, 1'b0);
    // Saturation in S3, absorbed by scaling, and the -min*-min product corner
    send({4{16'h7FFF}}, 64'd0, W_ONE, 48'd0, 1'b0, 1'b1, 1'b1,
         {48'd0, 16'h7FFF}, 64'd0, 1'b1);
    send({4{16'h7FFF}}, 64'd0, W_ONE, 48'd0, 1'b1, 1'b1, 1'b1,
         {48'd0, 16'h7FFF}, 64'd0, 1'b0);
    send({32'd0, 16'h8000, 16'h0000}, 64'd0, {32'd0, 16'h8000}, 48'd0, 1'b0, 1'b1, 1'b1,
         {16'h0000, 16'h8001, 16'h0000, 16'h7FFF},
         {16'h7FFF, 16'h0000, 16'h8001, 16'h0000}, 1'b1);
    drain();

    // Backpressure: six back-to-back vectors against a blocked output
    out_ready = 1'b0;
    acc0 = n_acc;
    fork
      begin
        for (int v = 0; v < 6; v++) begin
          rnd_vec(xr, xi, wr, wi);
          send(xr, xi, wr, wi, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        end
      end
      begin
        idle(8);
        @(negedge clk);
        chk("bp_accepts", 64'(n_acc - acc0), 64'd3);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Random vectors with random output stalls
    done = 1'b0;
    fork
      begin
        for (int v = 0; v < 24; v++) begin
          rnd_vec(xr, xi, wr, wi);
          send(xr, xi, wr, wi, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          idle(1);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with all three stages full
    out_ready = 1'b0;
    for (int v = 0; v < 3; v++) begin
      rnd_vec(xr, xi, wr, wi);
      send(xr | 64'h1, xi, wr, wi, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
    end
    chk("full_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_y_r", y_r, 64'd0);
    chk("mid_rst_y_i", y_i, 64'd0);
    chk("mid_rst_ovf", 64'(out_ovf), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
`ifdef PE_OVF_CNT_EN
    chk("mid_rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
`endif
    in_valid = 1'b1;
    idle(2);
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b1;
    for (int v = 0; v < 4; v++) begin
      chk("post_rst_idle", 64'(out_valid), 64'd0);
      idle(1);
    end
    send({48'd0, 16'h0400}, 64'd0, W_ONE, 48'd0, 1'b0, 1'b1, 1'b1,
         {4{16'h0400}}, 64'd0, 1'b0);
    drain();

`ifdef PE_OVF_CNT_EN
    for (int v = 0; v < 3; v++)
      send({4{16'h7FFF}}, 64'd0, W_ONE, 48'd0, 1'b0, 1'b1, 1'b1,
           {48'd0, 16'h7FFF}, 64'd0, 1'b1);
    drain();
    chk("ovf_cnt_3", 64'(ovf_cnt), 64'd3);
    ovf_clr = 1'b1;
    send({4{16'h7FFF}}, 64'd0, W_ONE, 48'd0, 1'b0, 1'b1, 1'b1,
         {48'd0, 16'h7FFF}, 64'd0, 1'b1);
    drain();
    ovf_clr = 1'b0;
    idle(1);
    chk("ovf_cnt_clr", 64'(ovf_cnt), 64'd0);
`endif

    idle(2);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
